// File: rtl/an_code_pkg.sv
// Shared AN-code helpers: status codes, Barrett constant and the
// elaboration-time single-error syndrome table builder.
package an_code_pkg;

    localparam logic [1:0] ST_CLEAN = 2'b00;
    localparam logic [1:0] ST_CORR  = 2'b01;
    localparam logic [1:0] ST_UNC   = 2'b10;

    typedef struct packed {
        logic       hit;
        logic       sign;   // 1: error was -2^idx, correction adds 2^idx
        logic [7:0] idx;
    } syn_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < v) r = k + 1;
        end
        return r;
    endfunction

    function automatic int pow2_mod(input int i, input int a);
        int p;
        p = 1 % a;
        for (int k = 0; k < i; k++) p = (p * 2) % a;
        return p;
    endfunction

    function automatic longint barrett_m(input int a, input int bk);
        return (longint'(1) << bk) / longint'(a);
    endfunction

    // Walks i downward so the lowest matching bit position is the one kept.
    function automatic syn_t syn_lookup(input int a, input int cw_w, input int r);
        syn_t s;
        int   p;
        s = '0;
        if (r > 0 && r < a) begin
            for (int i = cw_w - 1; i >= 0; i--) begin
                p = pow2_mod(i, a);
                if (p == r) begin
                    s.hit  = 1'b1;
                    s.sign = 1'b0;
                    s.idx  = 8'(i);
                end else if (a - p == r) begin
                    s.hit  = 1'b1;
                    s.sign = 1'b1;
                    s.idx  = 8'(i);
                end
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/an_barrett_divmod.sv
// Combinational Barrett divide of a W-bit unsigned by constant A: q = x / A, r = x % A.
// The estimate (x*m)>>BK is at most one low, fixed by a single conditional subtract.
module an_barrett_divmod
    import an_code_pkg::*;
#(
    parameter int A  = 29,
    parameter int W  = 14,
    parameter int BK = 28
) (
    input  logic [W-1:0]        x,
    output logic [W-1:0]        q,
    output logic [clog2(A)-1:0] r
);
    localparam int             RW = clog2(A);
    localparam int             PW = W + BK + 1;
    localparam logic [PW-1:0]  M  = PW'(barrett_m(A, BK));
    localparam logic [W:0]     AW = (W + 1)'(A);

    logic [PW-1:0] prod;
    logic [W-1:0]  q0;
    logic [W:0]    rem;

    assign prod = PW'(x) * M;
    assign q0   = W'(prod >> BK);
    assign rem  = {1'b0, x} - {1'b0, q0} * AW;

    always_comb begin
        if (rem >= AW) begin
            q = q0 + W'(1);
            r = RW'(rem - AW);
        end else begin
            q = q0;
            r = RW'(rem);
        end
    end

endmodule

// File: rtl/an_decoder_pipe.sv
// AN-code decoder, 3-stage valid/ready pipe: residue, single-error correction, divide by A.
// Define AN_DEC_STATS_EN for saturating corrected/uncorrectable output counters.
module an_decoder_pipe
    import an_code_pkg::*;
#(
    parameter int A     = 29,
    parameter int CW_W  = 14,
    parameter int MSG_W = 10,
    parameter int RES_W = 5,
    parameter int BK    = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CW_W-1:0]       in_cw,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MSG_W-1:0]      out_msg,
    output logic [1:0]            out_status,
    output logic [clog2(CW_W):0]  out_epos,
    output logic [15:0]           stat_corr,
    output logic [15:0]           stat_unc
);
    localparam int EPOS_W = clog2(CW_W) + 1;
    // Two extra bits: cw + 2^(CW_W-1) needs CW_W+1 magnitude bits plus a sign.
    localparam int FIX_W  = CW_W + 2;

    logic                adv;
    logic                s1_vld;
    logic [CW_W-1:0]     s1_cw;
    logic                s2_vld;
    logic [CW_W-1:0]     s2_cw;
    logic [RES_W-1:0]    s2_r;
    logic [RES_W-1:0]    res;
    logic [CW_W-1:0]     s2_q_unused;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    an_barrett_divmod #(.A(A), .W(CW_W), .BK(BK)) u_residue (
        .x (s1_cw),
        .q (s2_q_unused),
        .r (res)
    );

    syn_t syn_tab [2**RES_W];
    for (genvar g = 0; g < 2**RES_W; g++) begin : g_syn
        assign syn_tab[g] = syn_lookup(A, CW_W, g);
    end

    syn_t                syn;
    logic [FIX_W-1:0]    pw;
    logic [FIX_W-1:0]    fix;
    logic [CW_W-1:0]     q3;
    logic [RES_W-1:0]    r3_unused;
    logic                unc;
    logic [1:0]          st_nxt;
    logic [MSG_W-1:0]    msg_nxt;
    logic [EPOS_W-1:0]   epos_nxt;

    assign syn = syn_tab[s2_r];
    assign pw  = syn.hit ? (FIX_W'(1) << syn.idx) : '0;
    assign fix = syn.sign ? FIX_W'(s2_cw) + pw : FIX_W'(s2_cw) - pw;

    an_barrett_divmod #(.A(A), .W(CW_W), .BK(BK)) u_quotient (
        .x (fix[CW_W-1:0]),
        .q (q3),
        .r (r3_unused)
    );

    always_comb begin
        unc = ((s2_r != '0) && !syn.hit) || fix[FIX_W-1] || fix[CW_W] || (|(q3 >> MSG_W));
        st_nxt   = ST_CLEAN;
        msg_nxt  = MSG_W'(q3);
        epos_nxt = '0;
        if (unc) begin
            st_nxt  = ST_UNC;
            msg_nxt = '0;
        end else if (syn.hit) begin
            st_nxt   = ST_CORR;
            epos_nxt = {syn.sign, (EPOS_W - 1)'(syn.idx)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld     <= 1'b0;
            s1_cw      <= '0;
            s2_vld     <= 1'b0;
            s2_cw      <= '0;
            s2_r       <= '0;
            out_valid  <= 1'b0;
            out_msg    <= '0;
            out_status <= ST_CLEAN;
            out_epos   <= '0;
        end else if (adv) begin
            s1_vld    <= in_valid;
            s1_cw     <= in_cw;
            s2_vld    <= s1_vld;
            s2_cw     <= s1_cw;
            s2_r      <= res;
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_msg    <= msg_nxt;
                out_status <= st_nxt;
                out_epos   <= epos_nxt;
            end
        end
    end

`ifdef AN_DEC_STATS_EN
    logic xfer;
    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_corr <= '0;
            stat_unc  <= '0;
        end else if (xfer) begin
            if (out_status == ST_CORR && stat_corr != 16'hFFFF) stat_corr <= stat_corr + 16'd1;
            if (out_status == ST_UNC && stat_unc != 16'hFFFF) stat_unc <= stat_unc + 16'd1;
        end
    end
`else
    assign stat_corr = '0;
    assign stat_unc  = '0;
`endif

endmodule

// File: tb/tb_an_decoder_pipe.sv
// Scoreboard bench for an_decoder_pipe (A=29, CW_W=14, MSG_W=10): directed cases,
// stall/reset behaviour and a full single-error sweep.
module tb_an_decoder_pipe;

    typedef struct packed {
        logic [9:0] msg;
        logic [1:0] st;
        logic [4:0] epos;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_cw;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_msg;
    logic [1:0]  out_status;
    logic [4:0]  out_epos;
    logic [15:0] stat_corr;
    logic [15:0] stat_unc;

    int   checks   = 0;
    int   errors   = 0;
    int   exp_corr = 0;
    int   exp_unc  = 0;
    res_t exp_q[$];
    res_t obs_q[$];

    an_decoder_pipe #(.A(29), .CW_W(14), .MSG_W(10), .RES_W(5), .BK(28)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cw      (in_cw),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_msg    (out_msg),
        .out_status (out_status),
        .out_epos   (out_epos),
        .stat_corr  (stat_corr),
        .stat_unc   (stat_unc)
    );

    always #5 clk = ~clk;

    // Output monitor: records every completed transfer.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1)
            obs_q.push_back({out_msg, out_status, out_epos});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [13:0] cw, input res_t e);
        int n;
        in_valid = 1'b1;
        in_cw    = cw;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout cw=%0d in_ready=%b required 1", cw, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(e);
        if (e.st == 2'b01) exp_corr++;
        else if (e.st == 2'b10) exp_unc++;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_cw     = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        checks++;
        if (out_msg !== 10'd0 || out_status !== 2'b00 || out_epos !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs got msg=%0d st=%b epos=%b required 0/00/00000", out_msg, out_status, out_epos);
        end
        checks++;
        if (stat_corr !== 16'd0 || stat_unc !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats got corr=%0d unc=%0d required 0/0", stat_corr, stat_unc);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %b required 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        send(14'd145, {10'd5, 2'b00, 5'd0});
        send(14'd153, {10'd5, 2'b01, 5'b00011});
        send(14'd144, {10'd5, 2'b01, 5'b10000});
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %b required 1", out_valid); end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b required 1", in_ready); end
        exp_q.delete();
        obs_q.delete();
        exp_corr = 0;
        exp_unc  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_leak got %0d outputs required 0", obs_q.size()); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_post_valid got %b required 0", out_valid); end
        obs_q.delete();
    endtask

    task automatic test_directed();
        res_t o, e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_cw    = 14'd145;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back({10'd5, 2'b00, 5'd0});
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early got out_valid=%b required 0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_3 got out_valid=%b required 1", out_valid); end
        @(posedge clk);
        #1;
        send(14'd153,   {10'd5,   2'b01, 5'b00011});
        send(14'd144,   {10'd5,   2'b01, 5'b10000});
        send(14'd3,     {10'd0,   2'b10, 5'd0});
        send(14'd16383, {10'd0,   2'b10, 5'd0});
        send(14'd0,     {10'd0,   2'b00, 5'd0});
        send(14'd16356, {10'd564, 2'b00, 5'd0});
        wait_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL directed_count got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL directed_out got msg=%0d st=%b epos=%b required msg=%0d st=%b epos=%b",
                         o.msg, o.st, o.epos, e.msg, e.st, e.epos);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_stall();
        res_t o, e;
        bit   saw_block;
        saw_block = 1'b0;
        @(posedge clk);
        #1;
        fork
            begin
                send(14'd145, {10'd5, 2'b00, 5'd0});
                send(14'd153, {10'd5, 2'b01, 5'b00011});
                send(14'd144, {10'd5, 2'b01, 5'b10000});
            end
            begin
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (in_ready === 1'b0) saw_block = 1'b1;
                    if (out_valid === 1'b1) begin
                        checks++;
                        if (out_msg !== 10'd5 || out_status !== 2'b00 || out_epos !== 5'd0) begin
                            errors++;
                            $display("FAIL stall_hold got msg=%0d st=%b epos=%b required 5/00/00000",
                                     out_msg, out_status, out_epos);
                        end
                    end
                    @(posedge clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        checks++;
        if (!saw_block) begin errors++; $display("FAIL stall_in_ready got in_ready never 0, required a drop"); end
        wait_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall_order got msg=%0d st=%b epos=%b required msg=%0d st=%b epos=%b",
                         o.msg, o.st, o.epos, e.msg, e.st, e.epos);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_sweep();
        res_t o, e;
        bit   done;
        int   v;
        int   shown;
        done  = 1'b0;
        shown = 0;
        @(posedge clk);
        #1;
        fork
            begin
                for (int m = 0; m <= 564; m++) begin
                    for (int i = 0; i < 14; i++) begin
                        for (int s = 0; s < 2; s++) begin
                            v = (s == 0) ? (29 * m + (1 << i)) : (29 * m - (1 << i));
                            if (v >= 0 && v <= 16383) begin
                                e.msg  = 10'(m);
                                e.st   = 2'b01;
                                e.epos = {s[0], 4'(i)};
                                send(14'(v), e);
                            end
                        end
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sweep_count got %0d outputs required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL sweep_out got msg=%0d st=%b epos=%b required msg=%0d st=%b epos=%b",
                             o.msg, o.st, o.epos, e.msg, e.st, e.epos);
                end
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_stats();
`ifdef AN_DEC_STATS_EN
        checks++;
        if (stat_corr !== 16'(exp_corr)) begin
            errors++;
            $display("FAIL stats_corr got %0d required %0d", stat_corr, exp_corr);
        end
        checks++;
        if (stat_unc !== 16'(exp_unc)) begin
            errors++;
            $display("FAIL stats_unc got %0d required %0d", stat_unc, exp_unc);
        end
`else
        checks++;
        if (stat_corr !== 16'd0) begin errors++; $display("FAIL stats_corr_off got %0d required 0", stat_corr); end
        checks++;
        if (stat_unc !== 16'd0) begin errors++; $display("FAIL stats_unc_off got %0d required 0", stat_unc); end
`endif
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_directed();
        test_stall();
        test_sweep();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
